// File: rtl/multi_timer.sv
// multi_timer: CH independent one-shot/periodic down-count timers.
// A rising edge on trig[i] loads channel i with load[i*N +: N]; the channel
// counts down and raises out_pulse[i] for one cycle at terminal count.
// In periodic mode the channel reloads and repeats until stopped or retriggered.

module multi_timer #(
  parameter int N  = 8,
  parameter int CH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   trig,
  input  logic [CH*N-1:0] load,
  input  logic [CH-1:0]   mode,
  input  logic [CH-1:0]   stop,
  output logic [CH-1:0]   out_pulse,
  output logic [CH-1:0]   busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [N-1:0] CNT_ONE  = N'(1);
  localparam logic [N-1:0] CNT_ZERO = '0;

  state_t         state  [CH];
  logic [N-1:0]   cnt    [CH];
  logic [N-1:0]   reload [CH];
  logic [N-1:0]   load_ch[CH];
  logic [CH-1:0]  trig_r;
  logic [CH-1:0]  trig_rise;
  logic [CH-1:0]  mode_l;

  // Unpack per-channel load values, detect trigger rising edges, derive busy.
  // NOTE: every always_comb output gets a default first so no path can leave it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    trig_rise = trig & ~trig_r;
    busy      = '0;
    for (int i = 0; i < CH; i++) begin
      load_ch[i] = load[i*N +: N];
      busy[i]    = (state[i] == RUN);
    end
  end

  // Per-channel timer FSM: stop > valid edge > terminal count > decrement > hold.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these arrays are ordinary per-channel flops (not a RAM), so
      // resetting them is cheap and keeps reload/mode_l defined after reset.
      trig_r    <= '0;
      mode_l    <= '0;
      out_pulse <= '0;
      for (int i = 0; i < CH; i++) begin
        state[i]  <= IDLE;
        cnt[i]    <= '0;
        reload[i] <= '0;
      end
    end else begin
      trig_r <= trig;
      for (int i = 0; i < CH; i++) begin
        if (stop[i]) begin
          // Abort wins over everything, including a coincident edge.
          cnt[i]       <= '0;
          state[i]     <= IDLE;
          out_pulse[i] <= 1'b0;
        end else if (trig_rise[i] && (load_ch[i] != CNT_ZERO)) begin
          // Start or restart; a coincident terminal count is swallowed.
          cnt[i]       <= load_ch[i];
          reload[i]    <= load_ch[i];
          mode_l[i]    <= mode[i];
          state[i]     <= RUN;
          out_pulse[i] <= 1'b0;
        end else if ((state[i] == RUN) && (cnt[i] == CNT_ONE)) begin
          // Terminal count: pulse, then either finish or reload.
          out_pulse[i] <= 1'b1;
          if (mode_l[i]) begin
            cnt[i] <= reload[i];
          end else begin
            cnt[i]   <= '0;
            state[i] <= IDLE;
          end
        end else if ((state[i] == RUN) && (cnt[i] > CNT_ONE)) begin
          cnt[i]       <= cnt[i] - CNT_ONE;
          out_pulse[i] <= 1'b0;
        end else begin
          out_pulse[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: a deadline-based reference model pushes
// the expected out_pulse/busy vectors for every clock into a queue, and an
// independent monitor pops and compares them against the DUT each cycle.

module tb_multi_timer;

  localparam int N  = 8;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   trig;
  logic [CH*N-1:0] load;
  logic [CH-1:0]   mode;
  logic [CH-1:0]   stop;
  logic [CH-1:0]   out_pulse;
  logic [CH-1:0]   busy;

  multi_timer #(.N(N), .CH(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .trig      (trig),
    .load      (load),
    .mode      (mode),
    .stop      (stop),
    .out_pulse (out_pulse),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_seen[CH];

  typedef struct packed {
    logic [CH-1:0] pulse;
    logic [CH-1:0] busy;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: a channel is active with an absolute cycle
  // deadline for its next pulse; periodic channels push the deadline on.
  longint cyc = 0;
  bit     m_active  [CH];
  bit     m_periodic[CH];
  bit     m_prev    [CH];
  longint m_deadline[CH];
  longint m_period  [CH];

  task automatic check_vec(input string name, input logic [CH-1:0] act,
                           input logic [CH-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: evaluate the channel rules once per clock.
  always @(posedge clk) begin
    exp_t e;
    int   l;
    bit   rise;
    e = '0;
    cyc++;
    for (int i = 0; i < CH; i++) begin
      if (rst) begin
        m_active[i] = 0;
        m_prev[i]   = 0;
      end else begin
        rise      = trig[i] && !m_prev[i];
        m_prev[i] = trig[i];
        l         = int'(load[i*N +: N]);
        if (stop[i]) begin
          m_active[i] = 0;
        end else if (rise && l != 0) begin
          m_active[i]   = 1;
          m_deadline[i] = cyc + l;
          m_period[i]   = l;
          m_periodic[i] = mode[i];
        end else if (m_active[i] && cyc == m_deadline[i]) begin
          e.pulse[i] = 1'b1;
          if (m_periodic[i]) m_deadline[i] = m_deadline[i] + m_period[i];
          else m_active[i] = 0;
        end
      end
      e.busy[i] = m_active[i];
    end
    exp_q.push_back(e);
  end

  // Monitor: compare the DUT against the oldest expectation every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, required one entry (cycle %0d)", cyc);
    end else begin
      e = exp_q.pop_front();
      check_vec("out_pulse", out_pulse, e.pulse);
      check_vec("busy", busy, e.busy);
    end
    for (int i = 0; i < CH; i++) if (out_pulse[i] === 1'b1) pulse_seen[i]++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_load(input int ch, input int v);
    load[ch*N +: N] = N'(v);
  endtask

  task automatic fire(input int ch, input int l, input bit md);
    set_load(ch, l);
    mode[ch] = md;
    trig[ch] = 1'b1;
    step(1);
    trig[ch] = 1'b0;
  endtask

  task automatic stop_all();
    stop = '1;
    step(1);
    stop = '0;
    step(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int b[CH];
    rst  = 1'b1;
    trig = '0;
    load = '0;
    mode = '0;
    stop = '0;
    for (int i = 0; i < CH; i++) pulse_seen[i] = 0;
    step(3);
    rst = 1'b0;
    step(5);
    check_int("idle after reset ch0 pulses", pulse_seen[0], 0);

    // One-shot, load 5: one pulse only.
    base = pulse_seen[0];
    fire(0, 5, 1'b0);
    step(10);
    check_int("oneshot L5 pulses", pulse_seen[0] - base, 1);

    // Periodic, load 3: pulses after k+3, k+6, k+9.
    base = pulse_seen[1];
    fire(1, 3, 1'b1);
    step(9);
    check_int("periodic L3 pulses", pulse_seen[1] - base, 3);
    stop[1] = 1'b1;
    step(1);
    stop[1] = 1'b0;
    check_vec("busy after stop ch1", busy, '0);
    step(5);
    check_int("periodic L3 after stop", pulse_seen[1] - base, 3);

    // Periodic load 1: continuous pulse.
    base = pulse_seen[1];
    fire(1, 1, 1'b1);
    step(8);
    check_int("periodic L1 pulses", pulse_seen[1] - base, 8);
    stop_all();

    // Maximum delay 255.
    base = pulse_seen[0];
    fire(0, 255, 1'b0);
    step(254);
    check_int("L255 before deadline", pulse_seen[0] - base, 0);
    step(1);
    check_int("L255 at deadline", pulse_seen[0] - base, 1);
    step(3);

    // load 0 is ignored.
    base = pulse_seen[2];
    fire(2, 0, 1'b0);
    step(5);
    check_vec("load0 stays idle", busy, '0);
    check_int("load0 pulses", pulse_seen[2] - base, 0);

    // Retrigger: load 4 at k, load 6 at k+2 -> single pulse after k+8.
    base = pulse_seen[2];
    fire(2, 4, 1'b0);
    step(1);
    fire(2, 6, 1'b0);
    step(10);
    check_int("retrigger pulses", pulse_seen[2] - base, 1);

    // Edge coincident with terminal count suppresses that pulse.
    base = pulse_seen[2];
    fire(2, 3, 1'b0);
    step(2);
    fire(2, 3, 1'b0);
    step(5);
    check_int("edge at TC pulses", pulse_seen[2] - base, 1);

    // Stop at the second terminal count of a periodic load-4 channel.
    base = pulse_seen[3];
    fire(3, 4, 1'b1);
    step(7);
    stop[3] = 1'b1;
    step(1);
    stop[3] = 1'b0;
    step(6);
    check_int("stop at TC pulses", pulse_seen[3] - base, 1);

    // Held trigger does not restart after a stop.
    set_load(3, 4);
    mode[3] = 1'b1;
    trig[3] = 1'b1;
    step(1);
    stop[3] = 1'b1;
    step(1);
    stop[3] = 1'b0;
    step(10);
    check_vec("held trig no restart", busy, '0);
    trig[3] = 1'b0;
    step(1);

    // All channels concurrently with distinct loads and modes.
    for (int i = 0; i < CH; i++) b[i] = pulse_seen[i];
    set_load(0, 3); set_load(1, 5); set_load(2, 7); set_load(3, 2);
    mode = 4'b0101;
    trig = '1;
    step(1);
    trig = '0;
    step(20);
    check_int("concurrent ch0", pulse_seen[0] - b[0], 6);
    check_int("concurrent ch1", pulse_seen[1] - b[1], 1);
    check_int("concurrent ch2", pulse_seen[2] - b[2], 2);
    check_int("concurrent ch3", pulse_seen[3] - b[3], 1);
    stop_all();

    // Asynchronous reset in the middle of a run.
    for (int i = 0; i < CH; i++) set_load(i, 2);
    mode = '1;
    trig = '1;
    step(1);
    trig = '0;
    step(3);
    rst = 1'b1;
    #1;
    check_vec("async rst out_pulse", out_pulse, '0);
    check_vec("async rst busy", busy, '0);
    step(2);
    rst = 1'b0;
    step(5);

    // Trigger held high through reset release counts as an edge.
    base = pulse_seen[0];
    rst = 1'b1;
    set_load(0, 3);
    mode[0] = 1'b0;
    trig[0] = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    trig[0] = 1'b0;
    step(5);
    check_int("trig through reset pulses", pulse_seen[0] - base, 1);

    // Randomized stimulus against the reference model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < CH; i++) begin
        int r;
        if ($urandom_range(99) < 30) trig[i] = ~trig[i];
        r = int'($urandom_range(99));
        if (r < 8) set_load(i, 0);
        else if (r < 16) set_load(i, int'($urandom_range(255, 1)));
        else set_load(i, int'($urandom_range(12, 1)));
        mode[i] = 1'($urandom_range(1));
        stop[i] = ($urandom_range(99) < 3);
      end
      step(1);
    end
    trig = '0;
    stop = '0;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
